rice_core_alu_arbiter: RTL and testbench

//  Shares one rice_core_alu instance (instantiated inside) between REQUESTERS

---
 rtl/rice_core_alu_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_rice_core_alu_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rice_core_alu_arbiter.sv
// Shared rice_core_alu behind a round-robin valid/ready arbiter.
// Two-stage pipeline: operand register (A), result register (B).

package rice_core_alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef struct packed {
        logic [3:0] command;
        logic       op1_pc;
        logic       op2_imm;
    } rice_core_alu_operation;

endpackage

module rice_core_alu
    import rice_core_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]       pc,
    input  logic [XLEN-1:0]       rs1_value,
    input  logic [XLEN-1:0]       rs2_value,
    input  logic [XLEN-1:0]       imm_value,
    input  rice_core_alu_operation operation,
    output logic [XLEN-1:0]       result
);

    localparam int SHW = (XLEN == 64) ? 6 : 5;

    logic [XLEN-1:0] operand_1;
    logic [XLEN-1:0] operand_2;
    logic [SHW-1:0]  shamt;

    assign operand_1 = operation.op1_pc  ? pc        : rs1_value;
    assign operand_2 = operation.op2_imm ? imm_value : rs2_value;
    assign shamt     = operand_2[SHW-1:0];

    always_comb begin
        result = operand_1 + operand_2;
        case (operation.command)
            ALU_SUB:  result = operand_1 - operand_2;
            ALU_SLL:  result = operand_1 << shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}},
                                $signed(operand_1) < $signed(operand_2)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, operand_1 < operand_2};
            ALU_XOR:  result = operand_1 ^ operand_2;
            ALU_SRL:  result = operand_1 >> shamt;
            ALU_SRA:  result = $unsigned($signed(operand_1) >>> shamt);
            ALU_OR:   result = operand_1 | operand_2;
            ALU_AND:  result = operand_1 & operand_2;
            default:  result = operand_1 + operand_2;
        endcase
    end

endmodule

module rice_core_alu_arbiter
    import rice_core_alu_pkg::*;
#(
    parameter  int XLEN       = 32,
    parameter  int REQUESTERS = 2,
    localparam int ID_WIDTH   = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic [REQUESTERS-1:0]      i_req_valid,
    output logic [REQUESTERS-1:0]      o_req_ready,
    input  logic [REQUESTERS*XLEN-1:0] i_req_pc,
    input  logic [REQUESTERS*XLEN-1:0] i_req_rs1_value,
    input  logic [REQUESTERS*XLEN-1:0] i_req_rs2_value,
    input  logic [REQUESTERS*XLEN-1:0] i_req_imm_value,
    input  rice_core_alu_operation     i_req_operation [REQUESTERS],
    output logic                       o_result_valid,
    input  logic                       i_result_ready,
    output logic [XLEN-1:0]            o_result,
    output logic [ID_WIDTH-1:0]        o_result_id
);

    logic                      valid_a;
    logic                      valid_b;
    logic                      ready_a;
    logic                      ready_b;
    logic                      any_valid;
    logic                      accept;
    logic [ID_WIDTH-1:0]       ptr;
    logic [ID_WIDTH-1:0]       ptr_next;
    logic [ID_WIDTH-1:0]       grant_id;
    logic [ID_WIDTH:0]         grant_sum;
    logic [2*REQUESTERS-1:0]   valid_dbl;
    logic [REQUESTERS-1:0]     valid_rot;

    logic [XLEN-1:0]           pc_a;
    logic [XLEN-1:0]           rs1_a;
    logic [XLEN-1:0]           rs2_a;
    logic [XLEN-1:0]           imm_a;
    rice_core_alu_operation    op_a;
    logic [ID_WIDTH-1:0]       id_a;
    logic [XLEN-1:0]           alu_result;

    assign ready_b = !valid_b || i_result_ready;
    assign ready_a = !valid_a || ready_b;

    // Rotate valids so bit k is requester (ptr+k); lowest set k wins.
    always_comb begin
        valid_dbl = {i_req_valid, i_req_valid};
        valid_rot = valid_dbl[ptr +: REQUESTERS];
        grant_sum = {1'b0, ptr};
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                grant_sum = {1'b0, ptr} + (ID_WIDTH+1)'(k);
            end
        end
        if (grant_sum >= (ID_WIDTH+1)'(REQUESTERS)) begin
            grant_sum = grant_sum - (ID_WIDTH+1)'(REQUESTERS);
        end
        grant_id = grant_sum[ID_WIDTH-1:0];
    end

    assign any_valid = |i_req_valid;
    assign accept    = any_valid && ready_a && !i_flush;

    always_comb begin
        o_req_ready = '0;
        if (accept) begin
            o_req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        ptr_next = grant_id + 1'b1;
        if (int'(grant_id) == REQUESTERS - 1) begin
            ptr_next = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= ptr_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_a <= 1'b0;
        end else if (i_flush) begin
            valid_a <= 1'b0;
        end else if (ready_a) begin
            valid_a <= accept;
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            pc_a  <= i_req_pc[int'(grant_id)*XLEN +: XLEN];
            rs1_a <= i_req_rs1_value[int'(grant_id)*XLEN +: XLEN];
            rs2_a <= i_req_rs2_value[int'(grant_id)*XLEN +: XLEN];
            imm_a <= i_req_imm_value[int'(grant_id)*XLEN +: XLEN];
            op_a  <= i_req_operation[grant_id];
            id_a  <= grant_id;
        end
    end

    rice_core_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .pc        (pc_a),
        .rs1_value (rs1_a),
        .rs2_value (rs2_a),
        .imm_value (imm_a),
        .operation (op_a),
        .result    (alu_result)
    );

    // A result taken in the same cycle as a flush has already left.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_b     <= 1'b0;
            o_result    <= '0;
            o_result_id <= '0;
        end else if (i_flush) begin
            valid_b <= 1'b0;
        end else if (ready_b) begin
            valid_b <= valid_a;
            if (valid_a) begin
                o_result    <= alu_result;
                o_result_id <= id_a;
            end
        end
    end

    assign o_result_valid = valid_b;

endmodule

// File: tb/tb_rice_core_alu_arbiter.sv
// Directed bench for rice_core_alu_arbiter with a result scoreboard.
// Expected values come from an independent ALU model and constants.

module tb_rice_core_alu_arbiter;
    import rice_core_alu_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   flush;
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [63:0]            req_pc;
    logic [63:0]            req_rs1;
    logic [63:0]            req_rs2;
    logic [63:0]            req_imm;
    rice_core_alu_operation req_op [2];
    logic                   res_valid;
    logic                   res_ready;
    logic [31:0]            res;
    logic [0:0]             res_id;

    typedef struct {
        logic [31:0] value;
        logic [0:0]  id;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    int         pops     = 0;
    logic [1:0] acc_mask;

    always #5 clk = ~clk;

    rice_core_alu_arbiter #(
        .XLEN       (32),
        .REQUESTERS (2)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_flush         (flush),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_req_pc        (req_pc),
        .i_req_rs1_value (req_rs1),
        .i_req_rs2_value (req_rs2),
        .i_req_imm_value (req_imm),
        .i_req_operation (req_op),
        .o_result_valid  (res_valid),
        .i_result_ready  (res_ready),
        .o_result        (res),
        .o_result_id     (res_id)
    );

    function automatic rice_core_alu_operation mk(input logic [3:0] cmd,
                                                  input logic pcs,
                                                  input logic imms);
        rice_core_alu_operation o;
        o.command = cmd;
        o.op1_pc  = pcs;
        o.op2_imm = imms;
        return o;
    endfunction

    function automatic logic [31:0] model(input rice_core_alu_operation op,
                                          input logic [31:0] pc,
                                          input logic [31:0] rs1,
                                          input logic [31:0] rs2,
                                          input logic [31:0] imm);
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] ext;
        int          sh;
        a  = op.op1_pc ? pc : rs1;
        b  = op.op2_imm ? imm : rs2;
        sh = int'(b[4:0]);
        case (op.command)
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> sh;
            ALU_SRA: begin
                ext = {{32{a[31]}}, a} >> sh;
                return ext[31:0];
            end
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return a + b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input rice_core_alu_operation op,
                           input logic [31:0] pc, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [31:0] imm);
        req_op[i]          = op;
        req_pc[i*32 +: 32]  = pc;
        req_rs1[i*32 +: 32] = rs1;
        req_rs2[i*32 +: 32] = rs2;
        req_imm[i*32 +: 32] = imm;
    endtask

    // Samples handshakes in the low phase, then advances one clock.
    task automatic tick();
        exp_t e;
        #1;
        acc_mask = req_ready;
        chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
        for (int i = 0; i < 2; i++) begin
            if (req_ready[i]) begin
                e.value = model(req_op[i], req_pc[i*32 +: 32],
                                req_rs1[i*32 +: 32], req_rs2[i*32 +: 32],
                                req_imm[i*32 +: 32]);
                e.id = 1'(i);
                sb.push_back(e);
            end
        end
        if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_result", 64'(res_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_value", 64'(res), 64'(e.value));
                chk("sb_id", 64'(res_id), 64'(e.id));
                pops++;
            end
        end
        if (!rst_n || flush) sb.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_single(input string tag, input rice_core_alu_operation op,
                              input logic [31:0] pc, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [31:0] imm,
                              input logic [31:0] exp);
        res_ready = 1'b1;
        set_req(0, op, pc, rs1, rs2, imm);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        #1;
        chk({tag, "_valid"}, 64'(res_valid), 64'd1);
        chk(tag, 64'(res), 64'(exp));
        tick();
    endtask

    logic [3:0]  t3_cmd [4];
    logic [31:0] t3_a   [4];
    logic [31:0] t3_b   [4];
    int          n;
    int          p0;
    int          guard;

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 2'b00;
        res_ready = 1'b1;
        req_pc    = '0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_imm   = '0;
        req_op[0] = mk(ALU_ADD, 1'b0, 1'b0);
        req_op[1] = mk(ALU_ADD, 1'b0, 1'b0);
        @(negedge clk);
        tick();
        do_reset();

        #1;
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_result", 64'(res), 64'd0);
        chk("rst_id", 64'(res_id), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);

        // single ADD, latency two cycles, one-cycle pulse
        set_req(0, mk(ALU_ADD, 1'b0, 1'b0), 32'h0, 32'd5, 32'd7, 32'h0);
        req_valid = 2'b01;
        #1;
        chk("t1_ready", 64'(req_ready), 64'b01);
        tick();
        req_valid = 2'b00;
        #1;
        chk("t1_not_yet", 64'(res_valid), 64'd0);
        tick();
        #1;
        chk("t1_valid", 64'(res_valid), 64'd1);
        chk("t1_result", 64'(res), 64'd12);
        chk("t1_id", 64'(res_id), 64'd0);
        tick();
        #1;
        chk("t1_pulse_end", 64'(res_valid), 64'd0);
        tick();

        // both requesters streaming: alternating grants
        do_reset();
        set_req(0, mk(ALU_SUB, 1'b0, 1'b0), 32'h0, 32'd100, 32'd1, 32'h0);
        set_req(1, mk(ALU_XOR, 1'b0, 1'b0), 32'h0, 32'hF0F0, 32'h0FF0, 32'h0);
        req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t2_grant", 64'(req_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
            if (k >= 2) chk("t2_stream_valid", 64'(res_valid), 64'd1);
            if (k >= 2) chk("t2_stream_id", 64'(res_id), 64'(k % 2));
            tick();
            if (acc_mask[0]) req_rs1[31:0]  = req_rs1[31:0] + 32'd3;
            if (acc_mask[1]) req_rs1[63:32] = req_rs1[63:32] ^ 32'h11;
        end
        req_valid = 2'b00;
        tick();
        tick();

        // backpressure: 4 ops, consumer stalled for 4 cycles
        do_reset();
        t3_cmd = '{ALU_ADD, ALU_SUB, ALU_OR, ALU_AND};
        t3_a   = '{32'd10, 32'd50, 32'h0F00, 32'hFF00};
        t3_b   = '{32'd1, 32'd8, 32'h00F0, 32'h0FF0};
        n = 0;
        p0 = pops;
        res_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (n < 4) begin
                set_req(0, mk(t3_cmd[n], 1'b0, 1'b0), 32'h0, t3_a[n], t3_b[n], 32'h0);
                req_valid = 2'b01;
            end else begin
                req_valid = 2'b00;
            end
            if (k >= 2) begin
                #1;
                chk("t3_stall_valid", 64'(res_valid), 64'd1);
                chk("t3_stall_hold", 64'(res), 64'd11);
            end
            tick();
            if (acc_mask[0]) n++;
        end
        chk("t3_stalled_accepts", 64'(n), 64'd2);
        res_ready = 1'b1;
        guard = 0;
        while ((pops - p0) < 4 && guard < 20) begin
            if (n < 4) begin
                set_req(0, mk(t3_cmd[n], 1'b0, 1'b0), 32'h0, t3_a[n], t3_b[n], 32'h0);
                req_valid = 2'b01;
            end else begin
                req_valid = 2'b00;
            end
            tick();
            if (acc_mask[0]) n++;
            guard++;
        end
        chk("t3_all_results", 64'(pops - p0), 64'd4);

        // flush with both stages full
        do_reset();
        res_ready = 1'b0;
        set_req(0, mk(ALU_ADD, 1'b0, 1'b0), 32'h0, 32'd1, 32'd1, 32'h0);
        set_req(1, mk(ALU_ADD, 1'b0, 1'b0), 32'h0, 32'd2, 32'd2, 32'h0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b10;
        tick();
        flush     = 1'b1;
        req_valid = 2'b01;
        #1;
        chk("t4_flush_no_accept", 64'(req_ready), 64'b00);
        tick();
        flush     = 1'b0;
        req_valid = 2'b00;
        res_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_no_result", 64'(res_valid), 64'd0);
            tick();
        end
        req_valid = 2'b11;
        #1;
        chk("t4_ptr_kept", 64'(req_ready), 64'b01);
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        tick();

        // reset with both stages full
        do_reset();
        res_ready = 1'b0;
        set_req(1, mk(ALU_ADD, 1'b0, 1'b0), 32'h0, 32'd1, 32'd2, 32'h0);
        req_valid = 2'b10;
        tick();
        set_req(0, mk(ALU_ADD, 1'b0, 1'b0), 32'h0, 32'd3, 32'd4, 32'h0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        #1;
        chk("t5_full_result", 64'(res), 64'd3);
        chk("t5_full_id", 64'(res_id), 64'd1);
        do_reset();
        res_ready = 1'b1;
        #1;
        chk("t5_rst_valid", 64'(res_valid), 64'd0);
        chk("t5_rst_result", 64'(res), 64'd0);
        chk("t5_rst_id", 64'(res_id), 64'd0);
        req_valid = 2'b10;
        #1;
        chk("t5_req1_alone", 64'(req_ready), 64'b10);
        tick();
        req_valid = 2'b11;
        #1;
        chk("t5_ptr_zero", 64'(req_ready), 64'b01);
        tick();
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) tick();

        // ALU corner cases
        run_single("t6_sra", mk(ALU_SRA, 1'b0, 1'b0), 32'h0,
                   32'h8000_0000, 32'd4, 32'h0, 32'hF800_0000);
        run_single("t6_sll33", mk(ALU_SLL, 1'b0, 1'b0), 32'h0,
                   32'd1, 32'd33, 32'h0, 32'h0000_0002);
        run_single("t6_ltu", mk(ALU_SLTU, 1'b0, 1'b0), 32'h0,
                   32'd1, 32'hFFFF_FFFF, 32'h0, 32'd1);
        run_single("t6_ltu_neg", mk(ALU_SLTU, 1'b0, 1'b0), 32'h0,
                   32'hFFFF_FFFF, 32'd1, 32'h0, 32'd0);
        run_single("t6_lt_signed", mk(ALU_SLT, 1'b0, 1'b0), 32'h0,
                   32'hFFFF_FFFF, 32'd1, 32'h0, 32'd1);
        run_single("t6_srl", mk(ALU_SRL, 1'b0, 1'b0), 32'h0,
                   32'h8000_0000, 32'd4, 32'h0, 32'h0800_0000);
        run_single("t6_sub", mk(ALU_SUB, 1'b0, 1'b0), 32'h0,
                   32'd5, 32'd7, 32'h0, 32'hFFFF_FFFE);
        run_single("t6_unknown_pc_imm", mk(4'hF, 1'b1, 1'b1), 32'h100,
                   32'h5555, 32'h7777, 32'h20, 32'h120);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
